// File: rtl/mips_pkg.sv
// Shared MIPS core types and constants.
// Imported by the memory/writeback slice.
package mips_pkg;

    localparam int WORD_W     = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    function automatic logic is_aligned(input logic [WORD_W-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/memory_writeback_stage_if.sv
// EX/MEM inputs and MEM/WB outputs of the memory stage.
// master = EX side, slave = memory/writeback stage.
interface memory_writeback_stage_if #(
    parameter int CNT_W = 16
) ();
    import mips_pkg::*;

    logic                  regWriteM;
    logic                  memToRegM;
    logic                  memWriteM;
    logic [WORD_W-1:0]     aluOutM;
    logic [WORD_W-1:0]     writeDataM;
    logic [REG_ADDR_W-1:0] writeRegM;

    logic                  regWriteW;
    logic                  memToRegW;
    logic [WORD_W-1:0]     readDataW;
    logic [WORD_W-1:0]     aluOutW;
    logic [REG_ADDR_W-1:0] writeRegW;
    logic [WORD_W-1:0]     resultW;
    logic                  misalignW;
    logic [CNT_W-1:0]      loadCount;
    logic [CNT_W-1:0]      storeCount;

    modport master (
        output regWriteM, memToRegM, memWriteM,
        output aluOutM, writeDataM, writeRegM,
        input  regWriteW, memToRegW, readDataW, aluOutW,
        input  writeRegW, resultW, misalignW,
        input  loadCount, storeCount
    );

    modport slave (
        input  regWriteM, memToRegM, memWriteM,
        input  aluOutM, writeDataM, writeRegM,
        output regWriteW, memToRegW, readDataW, aluOutW,
        output writeRegW, resultW, misalignW,
        output loadCount, storeCount
    );

endinterface

// File: rtl/memory_writeback_stage_data_memory.sv
// Harvard data memory: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module data_memory #(
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/memory_writeback_stage.sv
// Memory stage + MEM/WB register: word loads/stores,
// misalignment fault flag and saturating debug counters.
module memory_writeback_stage
    import mips_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst,
    memory_writeback_stage_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [AW-1:0]     idx;
    logic [WORD_W-1:0] rdata;
    logic              aligned;
    logic              is_st;
    logic              is_ld;
    logic              we;

    logic                  reg_write_q,  reg_write_d;
    logic                  mem_to_reg_q, mem_to_reg_d;
    logic [WORD_W-1:0]     read_data_q,  read_data_d;
    logic [WORD_W-1:0]     alu_out_q,    alu_out_d;
    logic [REG_ADDR_W-1:0] write_reg_q,  write_reg_d;
    logic                  misalign_q,   misalign_d;
    logic [CNT_W-1:0]      load_cnt_q,   load_cnt_d;
    logic [CNT_W-1:0]      store_cnt_q,  store_cnt_d;

    // Upper address bits are dropped so accesses wrap.
    assign idx = bus.aluOutM[AW+1:2];

    always_comb begin
        aligned = is_aligned(bus.aluOutM);
        is_st   = bus.memWriteM;
        is_ld   = bus.memToRegM & ~bus.memWriteM;
        we      = is_st & aligned;
    end

    data_memory #(.DEPTH(DEPTH)) u_dmem (
        .clk   (clk),
        .we    (we),
        .addr  (idx),
        .wdata (bus.writeDataM),
        .rdata (rdata)
    );

    always_comb begin
        reg_write_d  = bus.regWriteM & (bus.writeRegM != ZERO_REG);
        mem_to_reg_d = bus.memToRegM;
        alu_out_d    = bus.aluOutM;
        write_reg_d  = bus.writeRegM;
        read_data_d  = '0;
        misalign_d   = misalign_q;
        load_cnt_d   = load_cnt_q;
        store_cnt_d  = store_cnt_q;
        if (is_ld && aligned) read_data_d = rdata;
        if ((is_st || is_ld) && !aligned) misalign_d = 1'b1;
        if (is_ld && aligned && load_cnt_q != CNT_MAX)
            load_cnt_d = load_cnt_q + 1'b1;
        if (is_st && aligned && store_cnt_q != CNT_MAX)
            store_cnt_d = store_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            read_data_q  <= '0;
            alu_out_q    <= '0;
            write_reg_q  <= '0;
            misalign_q   <= 1'b0;
            load_cnt_q   <= '0;
            store_cnt_q  <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            read_data_q  <= read_data_d;
            alu_out_q    <= alu_out_d;
            write_reg_q  <= write_reg_d;
            misalign_q   <= misalign_d;
            load_cnt_q   <= load_cnt_d;
            store_cnt_q  <= store_cnt_d;
        end
    end

    assign bus.regWriteW  = reg_write_q;
    assign bus.memToRegW  = mem_to_reg_q;
    assign bus.readDataW  = read_data_q;
    assign bus.aluOutW    = alu_out_q;
    assign bus.writeRegW  = write_reg_q;
    assign bus.resultW    = mem_to_reg_q ? read_data_q : alu_out_q;
    assign bus.misalignW  = misalign_q;
    assign bus.loadCount  = load_cnt_q;
    assign bus.storeCount = store_cnt_q;

endmodule

// File: tb/tb_memory_writeback_stage.sv
// Directed vector bench for memory_writeback_stage
// (DEPTH=64, CNT_W=4 so saturation is reachable).
module tb_memory_writeback_stage;

    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    memory_writeback_stage_if #(.CNT_W(CW)) bus ();

    memory_writeback_stage #(.DEPTH(64), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rw;
        logic        m2r;
        logic        mw;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  wr;
        logic        e_rw;
        logic        e_m2r;
        logic [31:0] e_rd;
        logic [4:0]  e_wr;
        logic [31:0] e_res;
        logic        e_mis;
        logic [3:0]  e_lc;
        logic [3:0]  e_sc;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic m2r, input logic mw,
                         input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] wr);
        bus.regWriteM  = rw;
        bus.memToRegM  = m2r;
        bus.memWriteM  = mw;
        bus.aluOutM    = alu;
        bus.writeDataM = wd;
        bus.writeRegM  = wr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #12;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        //        rw m2r mw alu           wd            wr  e_rw e_m2r e_rd          e_wr e_res         mis lc sc
        vecs[0]  = '{0, 0, 1, 32'h10,       32'hDEADBEEF, 0,  0, 0, 32'h0,        0,  32'h10,       0, 0, 1};
        vecs[1]  = '{1, 1, 0, 32'h10,       32'h0,        8,  1, 1, 32'hDEADBEEF, 8,  32'hDEADBEEF, 0, 1, 1};
        vecs[2]  = '{0, 0, 1, 32'h104,      32'h1234,     0,  0, 0, 32'h0,        0,  32'h104,      0, 1, 2};
        vecs[3]  = '{1, 1, 0, 32'h004,      32'h0,        9,  1, 1, 32'h1234,     9,  32'h1234,     0, 2, 2};
        vecs[4]  = '{0, 0, 1, 32'h20,       32'h5,        0,  0, 0, 32'h0,        0,  32'h20,       0, 2, 3};
        vecs[5]  = '{0, 0, 1, 32'h22,       32'hAA,       0,  0, 0, 32'h0,        0,  32'h22,       1, 2, 3};
        vecs[6]  = '{1, 1, 0, 32'h20,       32'h0,        10, 1, 1, 32'h5,        10, 32'h5,        1, 3, 3};
        vecs[7]  = '{1, 1, 0, 32'h21,       32'h0,        11, 1, 1, 32'h0,        11, 32'h0,        1, 3, 3};
        vecs[8]  = '{1, 0, 0, 32'h77,       32'h0,        0,  0, 0, 32'h0,        0,  32'h77,       1, 3, 3};
        vecs[9]  = '{1, 1, 1, 32'h30,       32'hCAFE,     12, 1, 1, 32'h0,        12, 32'h0,        1, 3, 4};
        vecs[10] = '{1, 1, 0, 32'h30,       32'h0,        13, 1, 1, 32'hCAFE,     13, 32'hCAFE,     1, 4, 4};
        vecs[11] = '{0, 0, 0, 32'h0,        32'h0,        0,  0, 0, 32'h0,        0,  32'h0,        1, 4, 4};
        vecs[12] = '{1, 0, 0, 32'hFFFFFFFC, 32'h1,        31, 1, 0, 32'h0,        31, 32'hFFFFFFFC, 1, 4, 4};

        drive(0, 0, 0, 0, 0, 0);
        #2;
        chk("reset_result", bus.resultW, 0);
        chk("reset_ctrl", {bus.regWriteW, bus.memToRegW, bus.misalignW,
                           bus.writeRegW}, 0);
        chk("reset_cnt", {bus.loadCount, bus.storeCount}, 0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rw, vecs[i].m2r, vecs[i].mw,
                  vecs[i].alu, vecs[i].wd, vecs[i].wr);
            step();
            chk($sformatf("v%0d_rd", i), bus.readDataW, vecs[i].e_rd);
            chk($sformatf("v%0d_res", i), bus.resultW, vecs[i].e_res);
            chk($sformatf("v%0d_alu", i), bus.aluOutW, vecs[i].alu);
            chk($sformatf("v%0d_ctl", i),
                {bus.regWriteW, bus.memToRegW, bus.writeRegW},
                {vecs[i].e_rw, vecs[i].e_m2r, vecs[i].e_wr});
            chk($sformatf("v%0d_mis", i), bus.misalignW, vecs[i].e_mis);
            chk($sformatf("v%0d_cnt", i), {bus.loadCount, bus.storeCount},
                {vecs[i].e_lc, vecs[i].e_sc});
        end

        // Mid-cycle async reset with random inputs applied
        @(negedge clk);
        drive(1, 1, 0, {$urandom} & 32'hFFFFFFFC, $urandom, 5'd7);
        step();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_result", bus.resultW, 0);
        chk("arst_data", bus.readDataW | bus.aluOutW, 0);
        chk("arst_ctrl", {bus.regWriteW, bus.memToRegW, bus.misalignW,
                          bus.writeRegW}, 0);
        chk("arst_cnt", {bus.loadCount, bus.storeCount}, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        chk("post_rst_mis", bus.misalignW, 0);
        chk("post_rst_cnt", {bus.loadCount, bus.storeCount}, 0);

        // Store right after reset release, then read it back
        do_reset();
        drive(0, 0, 1, 32'h40, 32'h99, 0);
        step();
        chk("first_store_cnt", bus.storeCount, 1);
        @(negedge clk);
        drive(1, 1, 0, 32'h40, 0, 3);
        step();
        chk("first_store_rd", bus.readDataW, 32'h99);

        // Store counter saturation
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 1, 32'(i * 4), 32'(i + 100), 0);
            step();
            if (i == 13) chk("sat_14", bus.storeCount, 14);
            if (i == 14) chk("sat_15", bus.storeCount, 15);
            @(negedge clk);
        end
        chk("sat_hold", bus.storeCount, 15);
        drive(1, 1, 0, 32'd76, 0, 4);
        step();
        chk("sat_last_rd", bus.readDataW, 32'd119);
        chk("sat_lc", bus.loadCount, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
